// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: FSM encoding and default timing values.
package cpu_clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP_HI = 3'd2,
        ST_STEP_LO = 3'd3,
        ST_HALTED  = 3'd4
    } state_t;

    localparam int DEF_DIV        = 500;
    localparam int DEF_DEB_CYCLES = 20000;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter and
// a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    assign w_done  = (r_cnt == CW'(DEB_CYCLES - 1));
    assign o_pulse = r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_sync2;
                r_pulse  <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU core clock generator: free-running divided clock or single-step periods,
// parking clk low after a complete period on halt or mode change.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    output logic             clk,
    output logic             cpu_tick,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int PW = (DIV < 1) ? 1 : $clog2(DIV + 1);

    state_t           r_state;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_phase;
    logic [1:0]       r_run_sync;
    logic [1:0]       r_halt_sync;

    state_t           w_state_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic [PW-1:0]    w_phase_nxt;
    logic             w_phase_end;
    logic             w_run;
    logic             w_halt;
    logic             w_step;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .i_clk   (sysclk),
        .i_reset (reset),
        .i_btn   (step_btn),
        .o_pulse (w_step)
    );

    assign w_run       = r_run_sync[1];
    assign w_halt      = r_halt_sync[1];
    assign w_phase_end = (r_phase == PW'(DIV));

    assign clk       = r_clk;
    assign cpu_tick  = r_tick;
    assign state     = r_state;
    assign cycle_cnt = r_cnt;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clk       <= 1'b0;
            r_tick      <= 1'b0;
            r_cnt       <= '0;
            r_phase     <= '0;
            r_run_sync  <= 2'b00;
            r_halt_sync <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_clk       <= w_clk_nxt;
            r_tick      <= w_tick_nxt;
            r_phase     <= w_phase_nxt;
            r_run_sync  <= {r_run_sync[0], run_sw};
            r_halt_sync <= {r_halt_sync[0], halt};
            if (w_tick_nxt) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_nxt = 1'b0;
                if (w_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_step) begin
                    w_state_nxt = ST_STEP_HI;
                    w_clk_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop decisions are taken only where a rise is due, so a high phase is never cut.
                if (w_phase_end) begin
                    if (r_clk) begin
                        w_clk_nxt = 1'b0;
                    end else if (w_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (!w_run) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_clk_nxt  = 1'b1;
                        w_tick_nxt = 1'b1;
                    end
                end
            end
            ST_STEP_HI: begin
                if (w_phase_end) begin
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = w_halt ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                w_clk_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clk_nxt   = 1'b0;
            end
        endcase
        w_phase_nxt = (w_state_nxt != r_state || w_phase_end) ? '0 : r_phase + PW'(1);
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl with short timing (DIV=3, DEB_CYCLES=4, CNT_W=4): expected
// rise cycles and counts are queued by the stimulus tasks and popped by a tick monitor.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  localparam int DIV   = 3;
  localparam int DEB   = 4;
  localparam int CNT_W = 4;
  localparam int HP    = DIV + 1;

  logic             sysclk = 1'b0;
  logic             reset;
  logic             run_sw;
  logic             step_btn;
  logic             halt;
  logic             clk;
  logic             cpu_tick;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_cnt = 0;

  logic [CNT_W-1:0] exp_q[$];
  int               exp_cyc_q[$];

  logic prev_clk = 1'b0;
  int   high_len = 0;

  cpu_clk_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .halt      (halt),
    .clk       (clk),
    .cpu_tick  (cpu_tick),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  // clock / cycle index (cyc = number of posedges so far)
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push_rise(input int r);
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    exp_cyc_q.push_back(r);
    exp_q.push_back(CNT_W'(model_cnt));
  endtask

  // monitor / scoreboard
  always @(negedge sysclk) begin
    if (reset) begin
      high_len = 0;
    end else begin
      if (cpu_tick) begin
        check("tick_on_rise", {30'd0, clk, prev_clk}, 32'd2);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tick at cycle %0d: cycle_cnt=%0d, no tick expected", cyc, cycle_cnt);
        end else begin
          check("tick_cycle", cyc, exp_cyc_q.pop_front());
          check("cycle_cnt", {28'd0, cycle_cnt}, {28'd0, exp_q.pop_front()});
        end
      end else if (clk && !prev_clk) begin
        check("rise_has_tick", {31'd0, cpu_tick}, 32'd1);
      end
      if (!clk && prev_clk) check("high_len", high_len, HP);
      high_len = clk ? high_len + 1 : 0;
    end
    prev_clk = clk;
  end

  // Start free-run (by reset release or run_sw rise), stop after dur cycles by run_sw drop or halt.
  task automatic run_seq(input bit by_reset, input int dur, input bit use_halt);
    int c, e, d, r;
    c = cyc;
    if (by_reset) reset = 1'b0;
    else run_sw = 1'b1;
    e = c + 3;
    d = c + dur;
    r = e + HP;
    while (r <= d + 2) begin
      push_rise(r);
      r += 2 * HP;
    end
    wait_cyc(e);
    check("run_entry", {29'd0, state}, int'(ST_RUN));
    wait_cyc(d);
    if (use_halt) halt = 1'b1;
    else run_sw = 1'b0;
    wait_cyc(r);
    check(use_halt ? "halt_state" : "run_stop_state", {29'd0, state},
          use_halt ? int'(ST_HALTED) : int'(ST_IDLE));
    check("parked_clk", {31'd0, clk}, 32'd0);
  endtask

  task automatic step_press(input int len);
    int p, idle, t;
    p = cyc;
    step_btn = 1'b1;
    idle = p;
    if (len >= DEB) begin
      push_rise(p + DEB + 3);
      idle = p + DEB + 3 + 2 * HP;
    end
    wait_cyc(p + len);
    step_btn = 1'b0;
    t = p + len + DEB + 4;
    wait_cyc((idle > t) ? idle : t);
    check("step_idle", {29'd0, state}, int'(ST_IDLE));
  endtask

  // Second clean press lands while the first step period is still in progress.
  task automatic step_double();
    int p, q;
    p = cyc;
    step_btn = 1'b1;
    push_rise(p + DEB + 3);
    wait_cyc(p + DEB);
    step_btn = 1'b0;
    q = p + DEB + 4;
    wait_cyc(q);
    step_btn = 1'b1;
    wait_cyc(q + DEB);
    step_btn = 1'b0;
    wait_cyc(q + 2 * DEB + 4);
    check("double_idle", {29'd0, state}, int'(ST_IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_sw = 1'b0;
    halt = 1'b0;
    step_btn = 1'b0;
    @(posedge sysclk);
    #1;
    check("rst_state", {29'd0, state}, int'(ST_IDLE));
    check("rst_clk", {31'd0, clk}, 32'd0);
    check("rst_cnt", {28'd0, cycle_cnt}, 32'd0);
    model_cnt = 0;
    repeat (2) begin
      @(posedge sysclk);
      #1;
    end
    reset = 1'b0;
    wait_cyc(cyc + 3);
  endtask

  task automatic reset_mid_high();
    int c, e, x, r;
    c = cyc;
    run_sw = 1'b1;
    e = c + 3;
    x = e + HP + 2 * HP * $urandom_range(0, 2) + $urandom_range(0, DIV);
    r = e + HP;
    while (r <= x) begin
      push_rise(r);
      r += 2 * HP;
    end
    wait_cyc(x);
    check("pre_reset_clk", {31'd0, clk}, 32'd1);
    reset = 1'b1;
    wait_cyc(x + 1);
    check("abort_clk", {31'd0, clk}, 32'd0);
    check("abort_cnt", {28'd0, cycle_cnt}, 32'd0);
    check("abort_state", {29'd0, state}, int'(ST_IDLE));
    model_cnt = 0;
    run_sw = 1'b0;
    wait_cyc(x + 3);
    reset = 1'b0;
    wait_cyc(x + 8);
    check("post_abort_state", {29'd0, state}, int'(ST_IDLE));
  endtask

  initial begin
    int k, j;
    reset = 1'b1;
    run_sw = 1'b1;
    step_btn = 1'b0;
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk);
      #1;
      check("init_state", {29'd0, state}, int'(ST_IDLE));
      check("init_clk", {31'd0, clk}, 32'd0);
      check("init_cnt", {28'd0, cycle_cnt}, 32'd0);
    end

    // long free-run from reset release: at least 17 rises, so cycle_cnt wraps
    run_seq(1'b1, $urandom_range(136, 170), 1'b0);
    repeat (3) run_seq(1'b0, $urandom_range(3, 40), 1'b0);

    // presses and glitches of random length
    repeat (8) step_press($urandom_range(1, 10));
    step_double();
    step_press(DEB);

    // run_sw drop parks clk, then a single step
    run_seq(1'b0, $urandom_range(3, 50), 1'b0);
    step_press(6);

    // halt raised inside a high phase
    k = $urandom_range(0, 2);
    j = $urandom_range(0, DIV);
    run_seq(1'b0, 3 + HP + 2 * HP * k + j, 1'b1);
    run_sw = 1'b1;
    wait_cyc(cyc + 5);
    step_btn = 1'b1;
    wait_cyc(cyc + 8);
    step_btn = 1'b0;
    wait_cyc(cyc + 30);
    check("halted_stays", {29'd0, state}, int'(ST_HALTED));
    check("halted_clk", {31'd0, clk}, 32'd0);
    do_reset();

    reset_mid_high();
    run_seq(1'b0, $urandom_range(10, 60), 1'b0);
    step_press($urandom_range(DEB, 9));

    wait_cyc(cyc + 10);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
